// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding,
// default PC width and the return-address-stack pointer sizing helper.
package pc_pkg;

  localparam int unsigned PC_W_DEF = 8;

  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4
  } pc_sel_e;

  // Bits needed to index a stack of 'depth' entries (ceil log2, minimum 1)
  function automatic int unsigned RAS_PTR_W(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Control/status bundle between the fetch controller (master) and the
// program-counter unit (slave).
interface pc_if
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RAS_DEPTH = 4
);

  logic                          Stall;
  logic                          Branch;
  logic [PC_W-1:0]               BranchOffset;
  logic                          Jump;
  logic [PC_W-1:0]               JumpTarget;
  logic                          Call;
  logic                          Ret;
  logic [PC_W-1:0]               CurrentPC;
  logic [RAS_PTR_W(RAS_DEPTH):0] RasDepth;
  logic                          RasUnderflow;

  modport master (
    output Stall, Branch, BranchOffset, Jump, JumpTarget, Call, Ret,
    input  CurrentPC, RasDepth, RasUnderflow
  );

  modport slave (
    input  Stall, Branch, BranchOffset, Jump, JumpTarget, Call, Ret,
    output CurrentPC, RasDepth, RasUnderflow
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry
// and keeps depth saturated, so later pops return the newest entries only.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = PC_W_DEF
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              push_data,
  output logic [W-1:0]              top,
  output logic [RAS_PTR_W(DEPTH):0] depth
);

  localparam int unsigned PTR_W = RAS_PTR_W(DEPTH);
  localparam int unsigned DW    = PTR_W + 1;
  localparam logic [DW-1:0] FULL_C = DW'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] sp_r;
  logic [DW-1:0]    depth_r;

  // Stack pointer (next free slot) and occupancy; push takes precedence over pop
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sp_r    <= '0;
      depth_r <= '0;
    end else if (push) begin
      sp_r <= sp_r + PTR_W'(1);
      if (depth_r != FULL_C) begin
        depth_r <= depth_r + DW'(1);
      end
    end else if (pop && (depth_r != '0)) begin
      sp_r    <= sp_r - PTR_W'(1);
      depth_r <= depth_r - DW'(1);
    end
  end

  // Entry storage carries no reset; only depth decides what is valid
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_r[sp_r] <= push_data;
    end
  end

  assign top   = mem_r[sp_r - PTR_W'(1)];
  assign depth = depth_r;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: priority encoder -> next-PC select -> PC register.
// Define PC_RAS_EN to build the return-address stack; without it Call acts as Jump and Ret is ignored.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned INC       = 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input logic CLK,
  input logic Reset,
  pc_if.slave bus
);

  localparam int unsigned DW = RAS_PTR_W(RAS_DEPTH) + 1;
  localparam logic [PC_W-1:0] INC_C   = PC_W'(INC);
  localparam logic [PC_W-1:0] RESET_C = PC_W'(RESET_PC);
`ifdef PC_RAS_EN
  localparam logic RAS_EN_C = 1'b1;
`else
  localparam logic RAS_EN_C = 1'b0;
`endif

  pc_sel_e         sel_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] next_pc_s;
  logic [PC_W-1:0] seq_pc_s;
  logic [PC_W-1:0] ras_top_s;
  logic [DW-1:0]   ras_depth_s;
  logic            ras_empty_s;
  logic            underflow_s;
  logic            uf_r;

  assign seq_pc_s    = pc_r + INC_C;
  assign ras_empty_s = (ras_depth_s == '0);

  // Priority encoder: Call > Jump > Ret > Branch > increment
  always_comb begin
    sel_s = SEL_INC;
    if (bus.Call) begin
      sel_s = RAS_EN_C ? SEL_CALL : SEL_JMP;
    end else if (bus.Jump) begin
      sel_s = SEL_JMP;
    end else if (bus.Ret && RAS_EN_C) begin
      sel_s = SEL_RET;
    end else if (bus.Branch) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_INC;
    end
  end

  // Next-PC mux; an empty-stack return falls through to the sequential PC
  always_comb begin
    next_pc_s = seq_pc_s;
    case (sel_s)
      SEL_INC:  next_pc_s = seq_pc_s;
      SEL_BR:   next_pc_s = pc_r + bus.BranchOffset;
      SEL_JMP:  next_pc_s = bus.JumpTarget;
      SEL_CALL: next_pc_s = bus.JumpTarget;
      SEL_RET: begin
        if (ras_empty_s) begin
          next_pc_s = seq_pc_s;
        end else begin
          next_pc_s = ras_top_s;
        end
      end
      default:  next_pc_s = seq_pc_s;
    endcase
  end

  assign underflow_s = !bus.Stall && (sel_s == SEL_RET) && ras_empty_s;

  // PC register; Stall freezes it regardless of control inputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_r <= RESET_C;
    end else if (!bus.Stall) begin
      pc_r <= next_pc_s;
    end
  end

  // Underflow flag is a single-cycle pulse following the offending Ret
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      uf_r <= 1'b0;
    end else begin
      uf_r <= underflow_s;
    end
  end

`ifdef PC_RAS_EN
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (!bus.Stall && (sel_s == SEL_CALL)),
    .pop       (!bus.Stall && (sel_s == SEL_RET) && !ras_empty_s),
    .push_data (seq_pc_s),
    .top       (ras_top_s),
    .depth     (ras_depth_s)
  );
`else
  assign ras_top_s   = '0;
  assign ras_depth_s = '0;
`endif

  assign bus.CurrentPC    = pc_r;
  assign bus.RasDepth     = ras_depth_s;
  assign bus.RasUnderflow = uf_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit; expectations cover both the stack and no-stack builds,
// plus a direct exercise of the pc_ras circular stack.
module tb_pc_unit;
  import pc_pkg::*;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       stall;
    logic       br;
    logic [7:0] off;
    logic       jmp;
    logic [7:0] tgt;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic [2:0] dep;
    logic       uf;
    logic [7:0] pc_nr;
  } vec_t;

  logic clk;
  logic reset;
  int unsigned pass_cnt;
  int unsigned total_cnt;
  vec_t vecs[$];

  logic       rs_push;
  logic       rs_pop;
  logic [7:0] rs_din;
  logic [7:0] rs_top;
  logic [2:0] rs_dep;

  pc_if #(.PC_W(8), .RAS_DEPTH(4)) bus ();

  pc_unit #(.PC_W(8), .INC(1), .RESET_PC(32'h10), .RAS_DEPTH(4)) dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  pc_ras #(.DEPTH(4), .W(8)) u_rs (
    .CLK       (clk),
    .Reset     (reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (rs_din),
    .top       (rs_top),
    .depth     (rs_dep)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic s, input logic b, input logic [7:0] o,
                         input logic j, input logic [7:0] t, input logic c, input logic r,
                         input logic [7:0] p, input logic [2:0] d, input logic u,
                         input logic [7:0] pn);
    vec_t v;
    v.name = n; v.stall = s; v.br = b; v.off = o; v.jmp = j; v.tgt = t;
    v.call = c; v.ret = r; v.pc = p; v.dep = d; v.uf = u; v.pc_nr = pn;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic b, input logic [7:0] o, input logic j,
                       input logic [7:0] t, input logic c, input logic r);
    bus.Stall = s; bus.Branch = b; bus.BranchOffset = o;
    bus.Jump = j; bus.JumpTarget = t; bus.Call = c; bus.Ret = r;
  endtask

  // pc/dep/uf are the stack-build expectations; pc_nr is the no-stack PC
  task automatic check_out(input string n, input logic [7:0] pc, input logic [2:0] d,
                           input logic u, input logic [7:0] pc_nr);
    chk({n, " pc"}, 32'(bus.CurrentPC), RAS_EN ? 32'(pc) : 32'(pc_nr));
    chk({n, " depth"}, 32'(bus.RasDepth), RAS_EN ? 32'(d) : 32'd0);
    chk({n, " underflow"}, 32'(bus.RasUnderflow), RAS_EN ? 32'(u) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c5_tgt [5];
    logic [7:0] c5_ret [4];
    logic [7:0] rs_val [5];
    pass_cnt  = 0;
    total_cnt = 0;
    c5_tgt = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h50};
    c5_ret = '{8'h42, 8'h32, 8'h22, 8'h12};
    rs_val = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    //       name          stl   br    off    jmp   tgt    call  ret   pc     dep   uf    pc_nr
    add_vec("jmp_fe",     1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b0, 8'hFE);
    add_vec("inc_ff",     1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 8'hFF);
    add_vec("wrap_00",    1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    add_vec("inc_01",     1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 8'h01);
    add_vec("stall1",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 8'h01);
    add_vec("stall2_ovr", 1'b1, 1'b1, 8'h05, 1'b1, 8'h99, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0, 8'h01);
    add_vec("jmp_20",     1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0, 8'h20);
    add_vec("br_neg16",   1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0, 8'h10);
    add_vec("jmp_20b",    1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0, 8'h20);
    add_vec("jmp_over_br",1'b0, 1'b1, 8'hF0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h40, 3'd0, 1'b0, 8'h40);
    add_vec("jmp_f8",     1'b0, 1'b0, 8'h00, 1'b1, 8'hF8, 1'b0, 1'b0, 8'hF8, 3'd0, 1'b0, 8'hF8);
    add_vec("br_wrap",    1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 3'd0, 1'b0, 8'h08);
    add_vec("jmp_05",     1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 3'd0, 1'b0, 8'h05);
    add_vec("call_80",    1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 3'd1, 1'b0, 8'h80);
    add_vec("ret_06",     1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 3'd0, 1'b0, 8'h81);
    add_vec("ret_under",  1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 3'd0, 1'b1, 8'h82);
    add_vec("uf_clear",   1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 3'd0, 1'b0, 8'h83);
    add_vec("ret_over_br",1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 8'h09, 3'd0, 1'b1, 8'h93);
    add_vec("stall_ret",  1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h09, 3'd0, 1'b0, 8'h93);
    add_vec("call_jmp",   1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b1, 1'b0, 8'h30, 3'd1, 1'b0, 8'h30);
    add_vec("ret_0a",     1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0A, 3'd0, 1'b0, 8'h34);
    add_vec("stall_call", 1'b1, 1'b0, 8'h00, 1'b0, 8'h60, 1'b1, 1'b0, 8'h0A, 3'd0, 1'b0, 8'h34);

    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    rs_din  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 8'h10, 3'd0, 1'b0, 8'h10);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].off, vecs[i].jmp, vecs[i].tgt,
            vecs[i].call, vecs[i].ret);
      step();
      check_out(vecs[i].name, vecs[i].pc, vecs[i].dep, vecs[i].uf, vecs[i].pc_nr);
    end

    // Five nested calls into a four-deep stack, then unwind past empty
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    step();
    check_out("c5_start", 8'h01, 3'd0, 1'b0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, c5_tgt[i], 1'b1, 1'b0);
      step();
      check_out($sformatf("c5_call%0d", i), c5_tgt[i], (i < 4) ? 3'(i + 1) : 3'd4, 1'b0,
                c5_tgt[i]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      step();
      check_out($sformatf("c5_ret%0d", i), c5_ret[i], 3'(3 - i), 1'b0, 8'(8'h51 + i));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check_out("c5_under", 8'h13, 3'd0, 1'b1, 8'h55);

    // Asynchronous reset asserted mid-cycle while a Call is pending
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0);
    step();
    check_out("pre_rst", 8'h80, 3'd1, 1'b0, 8'h80);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h90, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_rst", 8'h10, 3'd0, 1'b0, 8'h10);
    step();
    check_out("rst_hold", 8'h10, 3'd0, 1'b0, 8'h10);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_out("post_rst", 8'h11, 3'd0, 1'b0, 8'h11);

    // Direct stack check: overwrite on full, LIFO unwind, pop on empty ignored
    for (int i = 0; i < 5; i++) begin
      rs_push = 1'b1;
      rs_din  = rs_val[i];
      step();
      chk($sformatf("ras_push%0d depth", i), 32'(rs_dep), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    rs_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ras_top%0d", i), 32'(rs_top), 32'(rs_val[4 - i]));
      rs_pop = 1'b1;
      step();
      chk($sformatf("ras_pop%0d depth", i), 32'(rs_dep), 32'(3 - i));
    end
    step();
    chk("ras_empty_pop depth", 32'(rs_dep), 32'd0);
    rs_pop = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
